sr_config_loader: RTL and testbench

Parametrised successor to the dual shift-register generator. It loads a dynamic register (SIZESRDYN bits) and a static register (SIZESRSTAT bits) serially from signal_in, framed by SELDYN/SELSTAT.
- Shifting goes into per-channel shadow registers. A channel's latched output updates only when the frame length is exactly right.
- The previous latch contents are shifted out on signal_out for readback and daisy-chaining.
- Errors are reported through status flags.
- It sits between the serial configuration interface and the pixel/analog configuration latches.

---
 rtl/sr_config_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_sr_config_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_config_loader.sv
// Serial loader for a dynamic and a static configuration register with length-checked commit.
// Optional odd-parity trailer bit per frame: define PARITY_CHECK_EN.
module sr_config_loader #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SELDYN,
  input  logic                  SELSTAT,
  input  logic                  signal_in,
  input  logic                  CLR_ERR,
  output logic [SIZESRDYN-1:0]  DYNLATCH,
  output logic [SIZESRSTAT-1:0] STATLATCH,
  output logic                  signal_out,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  LEN_ERR,
  output logic                  SEL_ERR,
  output logic                  PAR_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT_DYN  = 2'd1,
    ST_SHIFT_STAT = 2'd2,
    ST_ABORT      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DYN_MAX  = CNT_W'(SIZESRDYN + 2);
  localparam logic [CNT_W-1:0] C_STAT_MAX = CNT_W'(SIZESRSTAT + 2);
`ifdef PARITY_CHECK_EN
  localparam logic [CNT_W-1:0] C_DYN_SZ   = CNT_W'(SIZESRDYN);
  localparam logic [CNT_W-1:0] C_STAT_SZ  = CNT_W'(SIZESRSTAT);
  localparam logic [CNT_W-1:0] C_DYN_FL   = CNT_W'(SIZESRDYN + 1);
  localparam logic [CNT_W-1:0] C_STAT_FL  = CNT_W'(SIZESRSTAT + 1);
`else
  localparam logic [CNT_W-1:0] C_DYN_FL   = CNT_W'(SIZESRDYN);
  localparam logic [CNT_W-1:0] C_STAT_FL  = CNT_W'(SIZESRSTAT);
`endif

  state_t                r_state, w_state_nxt;
  logic                  r_seldyn_q, r_selstat_q;
  logic [SIZESRDYN-1:0]  r_dyn_sh, w_dyn_sh_nxt, w_dynlatch_nxt;
  logic [SIZESRSTAT-1:0] r_stat_sh, w_stat_sh_nxt, w_statlatch_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  w_sout_nxt, w_done_nxt, w_len_set, w_sel_set;
  logic                  w_start_dyn, w_start_stat, w_rise_dyn, w_rise_stat;

`ifdef PARITY_CHECK_EN
  logic r_par_bit, w_par_bit_nxt, w_par_set;

  function automatic logic odd_par_dyn(input logic [SIZESRDYN-1:0] d);
    return ~^d;
  endfunction

  function automatic logic odd_par_stat(input logic [SIZESRSTAT-1:0] d);
    return ~^d;
  endfunction
`endif

  // A frame only starts on a select edge, so a select held through reset is ignored.
  assign w_rise_dyn  = SELDYN & ~r_seldyn_q;
  assign w_rise_stat = SELSTAT & ~r_selstat_q;
  assign BUSY        = (r_state == ST_SHIFT_DYN) || (r_state == ST_SHIFT_STAT);

  // Frame FSM: next state, shadow/latch updates and error events.
  always_comb begin
    w_state_nxt     = r_state;
    w_dyn_sh_nxt    = r_dyn_sh;
    w_stat_sh_nxt   = r_stat_sh;
    w_dynlatch_nxt  = DYNLATCH;
    w_statlatch_nxt = STATLATCH;
    w_cnt_nxt       = r_cnt;
    w_sout_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_len_set       = 1'b0;
    w_sel_set       = 1'b0;
    w_start_dyn     = 1'b0;
    w_start_stat    = 1'b0;
`ifdef PARITY_CHECK_EN
    w_par_bit_nxt   = r_par_bit;
    w_par_set       = 1'b0;
`endif
    if (SELDYN && SELSTAT) begin
      w_state_nxt   = ST_ABORT;
      w_sel_set     = 1'b1;
      w_dyn_sh_nxt  = '0;
      w_stat_sh_nxt = '0;
      w_cnt_nxt     = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_start_dyn  = w_rise_dyn;
          w_start_stat = w_rise_stat;
        end
        ST_SHIFT_DYN: begin
          if (SELDYN) begin
            w_cnt_nxt = (r_cnt >= C_DYN_MAX) ? C_DYN_MAX : r_cnt + C_ONE;
`ifdef PARITY_CHECK_EN
            if (r_cnt == C_DYN_SZ) begin
              w_par_bit_nxt = signal_in;
            end else begin
              w_dyn_sh_nxt = {r_dyn_sh[SIZESRDYN-2:0], signal_in};
              w_sout_nxt   = r_dyn_sh[SIZESRDYN-1];
            end
`else
            w_dyn_sh_nxt = {r_dyn_sh[SIZESRDYN-2:0], signal_in};
            w_sout_nxt   = r_dyn_sh[SIZESRDYN-1];
`endif
          end else begin
            w_state_nxt  = ST_IDLE;
            w_start_stat = w_rise_stat;
            if (r_cnt != C_DYN_FL) begin
              w_len_set = 1'b1;
`ifdef PARITY_CHECK_EN
            end else if (r_par_bit != odd_par_dyn(r_dyn_sh)) begin
              w_par_set = 1'b1;
`endif
            end else begin
              w_dynlatch_nxt = r_dyn_sh;
              w_done_nxt     = 1'b1;
            end
          end
        end
        ST_SHIFT_STAT: begin
          if (SELSTAT) begin
            w_cnt_nxt = (r_cnt >= C_STAT_MAX) ? C_STAT_MAX : r_cnt + C_ONE;
`ifdef PARITY_CHECK_EN
            if (r_cnt == C_STAT_SZ) begin
              w_par_bit_nxt = signal_in;
            end else begin
              w_stat_sh_nxt = {r_stat_sh[SIZESRSTAT-2:0], signal_in};
              w_sout_nxt    = r_stat_sh[SIZESRSTAT-1];
            end
`else
            w_stat_sh_nxt = {r_stat_sh[SIZESRSTAT-2:0], signal_in};
            w_sout_nxt    = r_stat_sh[SIZESRSTAT-1];
`endif
          end else begin
            w_state_nxt = ST_IDLE;
            w_start_dyn = w_rise_dyn;
            if (r_cnt != C_STAT_FL) begin
              w_len_set = 1'b1;
`ifdef PARITY_CHECK_EN
            end else if (r_par_bit != odd_par_stat(r_stat_sh)) begin
              w_par_set = 1'b1;
`endif
            end else begin
              w_statlatch_nxt = r_stat_sh;
              w_done_nxt      = 1'b1;
            end
          end
        end
        ST_ABORT: begin
          if (!SELDYN && !SELSTAT) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ABORT;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    // The first bit enters behind the old latch contents so they stream out for readback.
    if (w_start_dyn) begin
      w_state_nxt  = ST_SHIFT_DYN;
      w_dyn_sh_nxt = {DYNLATCH[SIZESRDYN-2:0], signal_in};
      w_sout_nxt   = DYNLATCH[SIZESRDYN-1];
      w_cnt_nxt    = C_ONE;
    end else if (w_start_stat) begin
      w_state_nxt   = ST_SHIFT_STAT;
      w_stat_sh_nxt = {STATLATCH[SIZESRSTAT-2:0], signal_in};
      w_sout_nxt    = STATLATCH[SIZESRSTAT-1];
      w_cnt_nxt     = C_ONE;
    end else begin
      w_cnt_nxt = w_cnt_nxt;
    end
  end

  // State, datapath and sticky-flag registers; a flag set beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_seldyn_q  <= 1'b1;
      r_selstat_q <= 1'b1;
      r_dyn_sh    <= '0;
      r_stat_sh   <= '0;
      r_cnt       <= '0;
      DYNLATCH    <= '0;
      STATLATCH   <= '0;
      signal_out  <= 1'b0;
      DONE        <= 1'b0;
      LEN_ERR     <= 1'b0;
      SEL_ERR     <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par_bit   <= 1'b0;
      PAR_ERR     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_seldyn_q  <= SELDYN;
      r_selstat_q <= SELSTAT;
      r_dyn_sh    <= w_dyn_sh_nxt;
      r_stat_sh   <= w_stat_sh_nxt;
      r_cnt       <= w_cnt_nxt;
      DYNLATCH    <= w_dynlatch_nxt;
      STATLATCH   <= w_statlatch_nxt;
      signal_out  <= w_sout_nxt;
      DONE        <= w_done_nxt;
      LEN_ERR     <= w_len_set | (LEN_ERR & ~CLR_ERR);
      SEL_ERR     <= w_sel_set | (SEL_ERR & ~CLR_ERR);
`ifdef PARITY_CHECK_EN
      r_par_bit   <= w_par_bit_nxt;
      PAR_ERR     <= w_par_set | (PAR_ERR & ~CLR_ERR);
`endif
    end
  end

`ifndef PARITY_CHECK_EN
  assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sr_config_loader.sv
// Randomised bench for sr_config_loader: frames are modelled as bit queues, committed
// when their length matches, with readback as old-latch-then-frame bit stream.
module tb_sr_config_loader;
  localparam int DYN  = 16;
  localparam int STAT = 88;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            rst, seldyn, selstat, din, clr;
  logic [DYN-1:0]  dynlatch;
  logic [STAT-1:0] statlatch;
  logic            sout, busy, done, len_err, sel_err, par_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DYN-1:0]  exp_dyn;
  logic [STAT-1:0] exp_stat;
  bit              exp_done, exp_len, exp_sel;
  bit              pend_active, pend_ch;
  bit              pend_bits[$];

  always #5 clk = ~clk;

  sr_config_loader #(.SIZESRSTAT(STAT), .SIZESRDYN(DYN), .CNT_W(CW)) dut (
    .CLK(clk), .RST(rst), .SELDYN(seldyn), .SELSTAT(selstat), .signal_in(din),
    .CLR_ERR(clr), .DYNLATCH(dynlatch), .STATLATCH(statlatch), .signal_out(sout),
    .BUSY(busy), .DONE(done), .LEN_ERR(len_err), .SEL_ERR(sel_err), .PAR_ERR(par_err)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input bit ch);
    return ch ? STAT : DYN;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick_len(input bit ch);
    int s;
    s = size_of(ch);
    case ($urandom_range(0, 5))
      0, 1, 2: return s;
      3:       return s - 1;
      4:       return s + 1;
      default: return $urandom_range(1, s + 4);
    endcase
  endfunction

  // End of the open frame: commit if it had exactly SIZE bits, else flag a length error.
  task automatic close_model(output bit len_set);
    logic [127:0] v;
    int s;
    len_set  = 1'b0;
    exp_done = 1'b0;
    if (pend_active) begin
      s = size_of(pend_ch);
      if (pend_bits.size() == s) begin
        v = '0;
        for (int k = 0; k < s; k++) v[s-1-k] = pend_bits[k];
        if (pend_ch) exp_stat = v[STAT-1:0];
        else         exp_dyn  = v[DYN-1:0];
        exp_done = 1'b1;
      end else begin
        len_set = 1'b1;
      end
    end
    pend_active = 1'b0;
    pend_bits.delete();
  endtask

  task automatic tick_check(input string tag, input bit e_sout, input bit e_busy);
    @(posedge clk);
    #1;
    check_eq({tag, ".sout"},  sout,      e_sout);
    check_eq({tag, ".busy"},  busy,      e_busy);
    check_eq({tag, ".done"},  done,      exp_done);
    check_eq({tag, ".dyn"},   dynlatch,  exp_dyn);
    check_eq({tag, ".stat"},  statlatch, exp_stat);
    check_eq({tag, ".len"},   len_err,   exp_len);
    check_eq({tag, ".sel"},   sel_err,   exp_sel);
    check_eq({tag, ".par"},   par_err,   1'b0);
  endtask

  // One frame on channel ch; its first bit also closes any frame open on the other channel.
  task automatic do_frame(input bit ch, input int len, input logic [127:0] pat);
    logic [127:0] old;
    bit b, ls;
    bit stream[$];
    int s;
    s = size_of(ch);
    for (int k = 0; k < len; k++) begin
      b = (len <= 128) ? pat[len-1-k] : 1'($urandom);
      seldyn  = !ch;
      selstat = ch;
      din     = b;
      clr     = 1'b0;
      if (k == 0) begin
        close_model(ls);
        exp_len = exp_len | ls;
        old = ch ? 128'(exp_stat) : 128'(exp_dyn);
        for (int j = s - 1; j >= 0; j--) stream.push_back(old[j]);
      end else begin
        exp_done = 1'b0;
      end
      stream.push_back(b);
      pend_bits.push_back(b);
      tick_check(ch ? "stat_bit" : "dyn_bit", stream[k], 1'b1);
    end
    pend_active = 1'b1;
    pend_ch     = ch;
  endtask

  // mode 0: never clear errors, 1: always, 2: random.
  task automatic idle(input int n, input int mode);
    bit ls, c;
    for (int i = 0; i < n; i++) begin
      c       = (mode == 1) || (mode == 2 && $urandom_range(0, 3) == 0);
      seldyn  = 1'b0;
      selstat = 1'b0;
      clr     = c;
      close_model(ls);
      exp_len = ls | (exp_len & !c);
      exp_sel = exp_sel & !c;
      tick_check("idle", 1'b0, 1'b0);
    end
    clr = 1'b0;
  endtask

  task automatic abort_seq(input bit ch, input int nbits);
    do_frame(ch, nbits, rnd128());
    seldyn  = 1'b1;
    selstat = 1'b1;
    din     = 1'($urandom);
    pend_active = 1'b0;
    pend_bits.delete();
    exp_done = 1'b0;
    exp_sel  = 1'b1;
    tick_check("abort", 1'b0, 1'b0);
    seldyn  = !ch;
    selstat = ch;
    tick_check("abort_hold", 1'b0, 1'b0);
    seldyn  = ch;
    selstat = !ch;
    tick_check("abort_swap", 1'b0, 1'b0);
    seldyn  = 1'b0;
    selstat = 1'b0;
    tick_check("abort_exit", 1'b0, 1'b0);
  endtask

  task automatic reset_mid();
    do_frame(1'b0, $urandom_range(1, 10), rnd128());
    rst     = 1'b1;
    seldyn  = 1'b1;
    selstat = 1'b0;
    din     = 1'b1;
    exp_dyn = '0; exp_stat = '0; exp_done = 1'b0; exp_len = 1'b0; exp_sel = 1'b0;
    pend_active = 1'b0;
    pend_bits.delete();
    repeat (2) tick_check("rst", 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) tick_check("rst_held", 1'b0, 1'b0);
    idle(2, 0);
  endtask

  initial begin
    bit ch;
    int len, op;
    rst = 1'b1; seldyn = 1'b0; selstat = 1'b0; din = 1'b0; clr = 1'b0;
    exp_dyn = '0; exp_stat = '0; exp_done = 1'b0; exp_len = 1'b0; exp_sel = 1'b0;
    pend_active = 1'b0; pend_ch = 1'b0;
    repeat (2) tick_check("reset", 1'b0, 1'b0);
    rst = 1'b0;
    idle(2, 0);

    do_frame(1'b0, DYN, 128'h8001);
    idle(2, 0);
    check_eq("dir_8001", dynlatch, 16'h8001);
    do_frame(1'b0, DYN, 128'hFFFF);
    do_frame(1'b1, STAT, 128'hA1B2C3D4E5F67890ABCDE1);
    idle(2, 0);
    check_eq("dir_ffff", dynlatch, 16'hFFFF);
    check_eq("dir_stat", statlatch, 88'hA1B2C3D4E5F67890ABCDE1);

    do_frame(1'b0, DYN - 1, rnd128());
    idle(1, 0);
    check_eq("len15_err", len_err, 1'b1);
    idle(1, 1);
    check_eq("len_clr", len_err, 1'b0);
    do_frame(1'b0, DYN + 1, rnd128());
    idle(1, 0);
    check_eq("len17_err", len_err, 1'b1);
    do_frame(1'b0, DYN + 256, rnd128());
    idle(1, 0);
    check_eq("len_long_keep", dynlatch, 16'hFFFF);

    abort_seq(1'b0, 5);
    check_eq("sel_err_set", sel_err, 1'b1);
    reset_mid();
    check_eq("rst_dyn_zero", dynlatch, 16'h0000);

    for (int it = 0; it < 40; it++) begin
      ch  = 1'($urandom_range(0, 1));
      len = pick_len(ch);
      op  = $urandom_range(0, 11);
      if (pend_active && pend_ch != ch && op < 4) begin
        do_frame(ch, len, rnd128());
      end else begin
        idle($urandom_range(1, 3), 2);
        if (op == 10)      abort_seq(ch, $urandom_range(1, 8));
        else if (op == 11) reset_mid();
        else               do_frame(ch, len, rnd128());
      end
    end
    idle(3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
